// File: rtl/ppl_mem_arbiter_if.sv
// Bundled CPU MEM-stage, DMA and data-memory signals for the arbiter.
// The slave modport is the arbiter; master is the requesters plus memory.
interface ppl_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_done;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rdata,
        output dma_gnt, dma_done, dma_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rdata,
        input  dma_gnt, dma_done, dma_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/ppl_mem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a DMA requester.
// Fixed-latency accesses, CPU priority with a bounded DMA starvation streak.
module ppl_mem_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk,
    input logic              clrn,
    ppl_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCpuAcc, StDmaAcc} state_e;

    localparam logic [3:0] LastCnt   = 4'(LAT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        dma_gnt_q, dma_gnt_d;
    logic        dma_done_q, dma_done_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic cpu_mem_req;
    logic last_cycle;
    logic gnt_cpu;
    logic gnt_dma;

    // IO addresses bypass the arbiter entirely.
    assign cpu_mem_req = bus.cpu_req & ~bus.cpu_addr[7];
    assign last_cycle  = (state_q != StIdle) && (cnt_q == LastCnt);

    always_comb begin
        gnt_cpu     = 1'b0;
        gnt_dma     = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        dma_rdata_d = dma_rdata_q;

        if (state_q == StIdle) begin
            if (cpu_mem_req && bus.dma_req) begin
                if (streak_q == StarveMax) gnt_dma = 1'b1;
                else                       gnt_cpu = 1'b1;
            end else if (cpu_mem_req) begin
                gnt_cpu = 1'b1;
            end else if (bus.dma_req) begin
                gnt_dma = 1'b1;
            end
        end

        if (gnt_cpu) begin
            state_d = StCpuAcc;
            cnt_d   = 4'd0;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            we_d    = bus.cpu_we;
        end else if (gnt_dma) begin
            state_d = StDmaAcc;
            cnt_d   = 4'd0;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
            we_d    = bus.dma_we;
        end else if (state_q != StIdle) begin
            if (last_cycle) begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        if (!bus.dma_req || gnt_dma) begin
            streak_d = 4'd0;
        end else if (gnt_cpu && (streak_q < StarveMax)) begin
            streak_d = streak_q + 4'd1;
        end

        dma_gnt_d  = gnt_dma;
        dma_done_d = last_cycle && (state_q == StDmaAcc);
        if (dma_done_d) dma_rdata_d = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            streak_q    <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            dma_gnt_q   <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            dma_gnt_q   <= dma_gnt_d;
            dma_done_q  <= dma_done_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q & (state_q != StIdle);
    assign bus.cpu_stall = cpu_mem_req & ~((state_q == StCpuAcc) && (cnt_q == LastCnt));
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_ppl_mem_arbiter.sv
// Directed bench for ppl_mem_arbiter: per-cycle vector table plus
// hand sequences for starvation order and reset abort.
module tb_ppl_mem_arbiter;
    logic clk = 1'b0;
    logic clrn;
    logic mem_init;
    logic [31:0] mem [256];

    int n_total = 0;
    int n_pass  = 0;

    ppl_mem_arbiter_if bus ();

    ppl_mem_arbiter #(
        .LAT        (2),
        .STARVE_MAX (4)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Data memory: word j holds 0xA0000000 + j until written.
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) mem[j] <= 32'hA000_0000 + 32'(j);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        cr;
        logic        cw;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        dr;
        logic [31:0] da;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_gnt;
        logic        e_done;
        logic [31:0] e_drd;
        logic        ck_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic [31:0] da,
                       input logic es, input logic ew, input logic [31:0] ea,
                       input logic [31:0] ed, input logic eg, input logic edn,
                       input logic [31:0] edr, input logic ck, input logic [31:0] erd);
        vec_t v;
        v = '{cr, cw, ca, cd, dr, da, es, ew, ea, ed, eg, edn, edr, ck, erd};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive_idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'd0;
        bus.dma_wdata = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string seq;
        string exp_order;
        int    dma_tail;
        logic [1:0] st;

        drive_idle();
        clrn     = 1'b0;
        mem_init = 1'b1;
        next_cycle();
        mem_init = 1'b0;
        clrn     = 1'b1;

        //   cr cw ca         cd            dr da      stl we addr      wdata        g  d  drd        ck rd
        add(0, 0, 32'h00, 32'h0,        0, 32'h00, 0, 0, 32'h00, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h40, 32'h0,        0, 32'h00, 1, 0, 32'h00, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h40, 32'h0,        0, 32'h00, 1, 0, 32'h40, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h40, 32'h0,        0, 32'h00, 0, 0, 32'h40, 32'h0,        0, 0, 32'h0, 1,
            32'hA000_0010);
        add(0, 0, 32'h00, 32'h0,        0, 32'h00, 0, 0, 32'h40, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h00, 1, 0, 32'h40, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h00, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0);
        add(1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h00, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h10, 32'h0,        0, 32'h00, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h10, 32'h0,        0, 32'h00, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h10, 32'h0,        0, 32'h00, 0, 0, 32'h10, 32'h0,        0, 0, 32'h0, 1,
            32'hDEADBEEF);
        add(1, 1, 32'h80, 32'h1234,     0, 32'h00, 0, 0, 32'h10, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(1, 1, 32'h80, 32'h1234,     0, 32'h00, 0, 0, 32'h10, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        1, 32'h20, 0, 0, 32'h10, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        1, 32'h20, 0, 0, 32'h20, 32'h0,        1, 0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        1, 32'h20, 0, 0, 32'h20, 32'h0,        0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        0, 32'h20, 0, 0, 32'h20, 32'h0,        0, 1,
            32'hA000_0008, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        0, 32'h00, 0, 0, 32'h20, 32'h0,        0, 0,
            32'hA000_0008, 0, 32'h0);
        add(1, 0, 32'h44, 32'h0,        0, 32'h00, 1, 0, 32'h20, 32'h0,        0, 0,
            32'hA000_0008, 0, 32'h0);
        // A DMA request raised and dropped during a CPU access is never granted.
        add(1, 0, 32'h44, 32'h0,        1, 32'h30, 1, 0, 32'h44, 32'h0,        0, 0,
            32'hA000_0008, 0, 32'h0);
        add(1, 0, 32'h44, 32'h0,        0, 32'h30, 0, 0, 32'h44, 32'h0,        0, 0,
            32'hA000_0008, 1, 32'hA000_0011);
        add(0, 0, 32'h00, 32'h0,        0, 32'h00, 0, 0, 32'h44, 32'h0,        0, 0,
            32'hA000_0008, 0, 32'h0);
        add(0, 0, 32'h00, 32'h0,        0, 32'h00, 0, 0, 32'h44, 32'h0,        0, 0,
            32'hA000_0008, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.cpu_req   = vecs[i].cr;
            bus.cpu_we    = vecs[i].cw;
            bus.cpu_addr  = vecs[i].ca;
            bus.cpu_wdata = vecs[i].cd;
            bus.dma_req   = vecs[i].dr;
            bus.dma_we    = 1'b0;
            bus.dma_addr  = vecs[i].da;
            bus.dma_wdata = 32'd0;
            @(negedge clk);
            chk($sformatf("row%0d cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_wdata);
            chk($sformatf("row%0d dma_gnt", i), 32'(bus.dma_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("row%0d dma_done", i), 32'(bus.dma_done), 32'(vecs[i].e_done));
            chk($sformatf("row%0d dma_rdata", i), bus.dma_rdata, vecs[i].e_drd);
            if (vecs[i].ck_rd) chk($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].e_rd);
            next_cycle();
        end

        // Both requesters held: four CPU grants, then one DMA grant, repeating.
        drive_idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h50;
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h60;
        seq      = "";
        dma_tail = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.dma_gnt) begin
                seq      = {seq, "D"};
                dma_tail = 2;
            end else if (!bus.cpu_stall) begin
                seq = {seq, "C"};
            end
            if (dma_tail > 0) begin
                chk($sformatf("starve cyc%0d stall during dma", c), 32'(bus.cpu_stall), 32'd1);
                dma_tail--;
            end
            next_cycle();
        end
        exp_order = "CCCCDCCCCD";
        chk("grant count", 32'(seq.len()), 32'(exp_order.len()));
        for (int k = 0; k < exp_order.len(); k++) begin
            chk($sformatf("grant order #%0d", k), 32'(seq[k]), 32'(exp_order[k]));
        end
        drive_idle();
        for (int c = 0; c < 3; c++) next_cycle();

        // Reset lands in the first cycle of a DMA write.
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h24;
        bus.dma_wdata = 32'h5555_AAAA;
        next_cycle();
        clrn          = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 32'h48;
        @(negedge clk);
        chk("abort dma_gnt", 32'(bus.dma_gnt), 32'd1);
        chk("abort mem_we before reset", 32'(bus.mem_we), 32'd1);
        chk("stall during reset", 32'(bus.cpu_stall), 32'd1);
        next_cycle();
        clrn = 1'b1;
        drive_idle();
        @(negedge clk);
        st = dut.state_q;
        chk("post-reset mem_we", 32'(bus.mem_we), 32'd0);
        chk("post-reset mem_addr", bus.mem_addr, 32'd0);
        chk("post-reset mem_wdata", bus.mem_wdata, 32'd0);
        chk("post-reset dma_rdata", bus.dma_rdata, 32'd0);
        chk("post-reset dma_gnt", 32'(bus.dma_gnt), 32'd0);
        chk("post-reset state", 32'(st), 32'd0);
        chk("post-reset streak", 32'(dut.streak_q), 32'd0);
        chk("post-reset dma_done", 32'(bus.dma_done), 32'd0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("no dma_done after abort +%0d", c), 32'(bus.dma_done), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ppl_mem_arbiter.md
PPL_MEM_ARBITER -- requirements
Module: ppl_mem_arbiter

Interface
REQ-001 Parameter LAT, default 2, is the data-memory access latency in clk cycles; legal values are 1 to 15.
REQ-002 Parameter STARVE_MAX, default 4, is the maximum number of consecutive CPU grants allowed while DMA waits; legal values are 1 to 15.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port clrn, input, 1 bit: synchronous, active-low reset.
REQ-005 Port cpu_req, input, 1 bit: MEM-stage load/store request, held asserted until served.
REQ-006 Port cpu_we, input, 1 bit: MEM-stage write enable.
REQ-007 Port cpu_addr, input, 32 bits: MEM-stage address; bit 7 set selects IO.
REQ-008 Port cpu_wdata, input, 32 bits: MEM-stage store data.
REQ-009 Port cpu_stall, output, 1 bit: freezes the pipeline.
REQ-010 Port cpu_rdata, output, 32 bits: load data, valid in the completion cycle.
REQ-011 Ports dma_req (input, 1), dma_we (input, 1), dma_addr (input, 32) and dma_wdata (input, 32): the secondary requester; the DMA holds all of them stable until dma_done.
REQ-012 Ports dma_gnt (output, 1) and dma_done (output, 1): one-cycle pulses.
REQ-013 Port dma_rdata, output, 32 bits: registered read data.
REQ-014 Ports mem_addr (output, 32), mem_wdata (output, 32) and mem_we (output, 1) drive the data memory.
REQ-015 Port mem_rdata, input, 32 bits: data-memory read data.

Function
REQ-016 FSM states SHALL be IDLE, CPU_ACC and DMA_ACC; a 4-bit counter cnt counts cycles within an access state.
REQ-017 A CPU request is a memory request only when cpu_req=1 and cpu_addr[7]=0.
REQ-018 An IO request (cpu_req=1, cpu_addr[7]=1) SHALL never stall, never reach the memory port and never be arbitrated.
REQ-019 In IDLE, arbitration SHALL be:
- CPU memory request and no dma_req: grant CPU.
- dma_req and no CPU memory request: grant DMA.
- Both requesting: grant DMA if streak==STARVE_MAX, else grant CPU.
REQ-020 On a grant, mem_addr, mem_wdata and the write flag SHALL be registered from the winning requester, the FSM SHALL enter CPU_ACC or DMA_ACC, and cnt SHALL be set to 0.
REQ-021 dma_gnt SHALL pulse in the cycle the DMA grant is registered, i.e. the first DMA_ACC cycle.
REQ-022 In an access state cnt SHALL increment each cycle; the cycle with cnt==LAT-1 is the completion cycle, after which the FSM returns to IDLE.
REQ-023 There is no back-to-back grant: at least one IDLE cycle SHALL separate accesses.
REQ-024 mem_we SHALL equal the registered write flag in every access-state cycle and 0 in IDLE.
REQ-025 cpu_stall SHALL be combinational: 1 when there is a CPU memory request and it is not the CPU_ACC completion cycle, else 0.
- The stall therefore covers the request cycle plus LAT-1 cycles.
- The stall stays high while a DMA access is in progress.
REQ-026 cpu_rdata SHALL equal mem_rdata combinationally.
REQ-027 dma_done SHALL pulse in the cycle after the DMA_ACC completion cycle, with dma_rdata registered from mem_rdata at completion; dma_rdata holds until the next DMA completion.
REQ-028 streak (4 bits) SHALL behave as follows:
- Increment on a CPU grant while dma_req=1, saturating at STARVE_MAX.
- Clear on a DMA grant.
- Clear in any cycle with dma_req=0.
REQ-029 Request inputs that change during an access SHALL have no effect until IDLE.
REQ-030 A requester that deasserts its request before a grant SHALL be dropped without side effect.

Reset
REQ-031 When clrn=0 at a rising edge, the block SHALL enter IDLE with cnt=0, streak=0 and mem_addr=mem_wdata=0.
- mem_we=0, dma_gnt=0 and dma_done=0 from the next cycle.
- dma_rdata=0.
REQ-032 A reset during an access SHALL abort it: no dma_done is issued and the write is not guaranteed.
REQ-033 cpu_stall SHALL follow REQ-025 during reset, so a CPU memory request stalls while clrn=0.

Verification
REQ-034 CPU load at 0x40, LAT=2: cpu_stall=1 in cycles 0-1, 0 in cycle 2; mem_addr=0x40 in cycles 1-2; cpu_rdata=mem_rdata in cycle 2.
REQ-035 CPU store of 0xDEADBEEF to 0x10: mem_we=1 exactly in cycles 1-2 with mem_wdata=0xDEADBEEF; an immediate re-read returns 0xDEADBEEF.
REQ-036 IO access at 0x80 with dma_req=0: cpu_stall=0, mem_we=0 and the FSM stays in IDLE.
REQ-037 DMA load at 0x20 alone: dma_gnt pulses in cycle 1; dma_done pulses in cycle 3 with dma_rdata=mem[0x20].
REQ-038 cpu_req and dma_req held continuously, STARVE_MAX=4: grant order is CPU, CPU, CPU, CPU, DMA, then repeating; cpu_stall=1 throughout the DMA access.
REQ-039 clrn=0 in cycle 1 of a DMA write: mem_we=0 from the next cycle, dma_done never pulses, and the FSM is in IDLE with streak=0.
